vga_frame_reader: RTL and testbench

- Display-side consumer of the data RAM's read-only port B.
- Generates 640x480@60 VGA timing from a 25 MHz pixel clock and drives address_b to fetch one 24-bit RGB888 word per visible image pixel.
- Delays sync and blank by the RAM read latency so colour and sync leave the block aligned.
- Sits in the clk_b domain, on the opposite port of the RAM that the memory stage writes through port A.

---
 rtl/vga_frame_reader.sv | 126 ++++++++++++
 tb/tb_vga_frame_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// Purpose: 640x480@60 VGA timing generator that streams one RGB888 word per image pixel from RAM port B.
// Latency: colour, syncs, blank and frame_start all leave READ_LATENCY cycles after the counters held a pixel.
// Backpressure: none; free-running at the pixel clock, and RAM port B must answer every cycle.
module vga_frame_reader #(
    parameter logic [17:0] BASE_ADDR    = 18'd0,
    parameter int          IMG_W        = 256,
    parameter int          IMG_H        = 256,
    parameter int          READ_LATENCY = 2,
    // Raster geometry; defaults are standard 640x480@60, overridable for short-raster builds
    parameter int          H_VISIBLE    = 640,
    parameter int          H_SYNC_START = 656,
    parameter int          H_SYNC_END   = 751,
    parameter int          H_TOTAL      = 800,
    parameter int          V_VISIBLE    = 480,
    parameter int          V_SYNC_START = 490,
    parameter int          V_SYNC_END   = 491,
    parameter int          V_TOTAL      = 525
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        en,
    input  logic [23:0] mem_data_b,
    output logic [17:0] address_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);

    localparam logic [9:0] H_VIS_L  = 10'(H_VISIBLE);
    localparam logic [9:0] H_SS_L   = 10'(H_SYNC_START);
    localparam logic [9:0] H_SE_L   = 10'(H_SYNC_END);
    localparam logic [9:0] H_LAST_L = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS_L  = 10'(V_VISIBLE);
    localparam logic [9:0] V_SS_L   = 10'(V_SYNC_START);
    localparam logic [9:0] V_SE_L   = 10'(V_SYNC_END);
    localparam logic [9:0] V_LAST_L = 10'(V_TOTAL - 1);
    localparam logic [9:0] IMG_W_L  = 10'(IMG_W);
    localparam logic [9:0] IMG_H_L  = 10'(IMG_H);

    // One pipeline slot: everything that must stay aligned with the RAM read
    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
        logic img;
        logic fs;
    } stage_t;

    localparam stage_t STAGE_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, img: 1'b0, fs: 1'b0};

    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [17:0] ptr_q, ptr_d;
    logic        active_q, active_d;
    logic        h_last;
    logic        frame_wrap;
    stage_t      raw;
    stage_t      pipe_q [READ_LATENCY];
    stage_t      out_s;

    // Raw timing from the counters plus next-state for counters, enable latch and pointer
    always_comb begin
        h_last     = (h_q == H_LAST_L);
        frame_wrap = h_last && (v_q == V_LAST_L);

        raw.hs  = !((h_q >= H_SS_L) && (h_q <= H_SE_L));
        raw.vs  = !((v_q >= V_SS_L) && (v_q <= V_SE_L));
        raw.vis = (h_q < H_VIS_L) && (v_q < V_VIS_L);
        raw.img = (h_q < IMG_W_L) && (v_q < IMG_H_L) && active_q;
        raw.fs  = (h_q == 10'd0) && (v_q == 10'd0) && active_q;

        h_d      = h_last ? 10'd0 : h_q + 10'd1;
        v_d      = v_q;
        active_d = active_q;
        ptr_d    = ptr_q;
        if (h_last) begin
            v_d = (v_q == V_LAST_L) ? 10'd0 : v_q + 10'd1;
        end
        if (frame_wrap) begin
            // en is only honoured at frame boundaries so a frame is never torn
            active_d = en;
            ptr_d    = BASE_ADDR;
        end else if (raw.img) begin
            // Row-major, no stride: the pointer simply pauses outside the image
            ptr_d = ptr_q + 18'd1;
        end
    end

    // Counter, enable latch, pointer and alignment shift register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_q      <= 10'd0;
            v_q      <= 10'd0;
            ptr_q    <= BASE_ADDR;
            active_q <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= STAGE_IDLE;
            end
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            ptr_q    <= ptr_d;
            active_q <= active_d;
            pipe_q[0] <= raw;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Last shift stage doubles as the output register; colour muxed with the matching RAM word
    always_comb begin
        out_s                 = pipe_q[READ_LATENCY-1];
        address_b             = ptr_q;
        vga_hs                = out_s.hs;
        vga_vs                = out_s.vs;
        vga_blank_n           = out_s.vis;
        frame_start           = out_s.fs;
        {vga_r, vga_g, vga_b} = out_s.img ? mem_data_b : 24'h0;
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
module tb_vga_frame_reader;

    typedef struct {
        int hv, hss, hse, ht;
        int vv, vss, vse, vt;
        int iw, ih, base, lat;
    } cfg_t;

    typedef struct {
        logic        hs, vs, blank_n, fs;
        logic [23:0] rgb;
        logic [17:0] addr;
    } exp_t;

    localparam int MAXK = 20000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        en;
    logic [23:0] salt;
    int          k;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          en_log [0:MAXK-1];
    cfg_t        cfg_a, cfg_b, cfg_d;

    always #5 CLK = ~CLK;

    // RAM contents: a salted identity so every address has a distinct, known word
    function automatic logic [23:0] ram_f(logic [17:0] a);
        return {6'b0, a} ^ salt;
    endfunction

    // ---------------- DUT A: small raster, 16x12 image, latency 2 ----------------
    logic [23:0] a_mem;
    logic [17:0] a_addr, a_a1;
    logic        a_hs, a_vs, a_bl, a_fs;
    logic [7:0]  a_r, a_g, a_b;
    always @(posedge CLK) begin
        a_a1  <= a_addr;
        a_mem <= ram_f(a_a1);
    end
    vga_frame_reader #(
        .BASE_ADDR(18'd100), .IMG_W(16), .IMG_H(12), .READ_LATENCY(2),
        .H_VISIBLE(40), .H_SYNC_START(44), .H_SYNC_END(47), .H_TOTAL(52),
        .V_VISIBLE(30), .V_SYNC_START(32), .V_SYNC_END(33), .V_TOTAL(36)
    ) u_a (
        .CLK(CLK), .RST(RST), .en(en), .mem_data_b(a_mem), .address_b(a_addr),
        .vga_hs(a_hs), .vga_vs(a_vs), .vga_blank_n(a_bl),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .frame_start(a_fs)
    );

    // ---------------- DUT B: small raster, full-screen image, latency 3 ----------------
    logic [23:0] b_mem;
    logic [17:0] b_addr, b_a1, b_a2;
    logic        b_hs, b_vs, b_bl, b_fs;
    logic [7:0]  b_r, b_g, b_b;
    always @(posedge CLK) begin
        b_a1  <= b_addr;
        b_a2  <= b_a1;
        b_mem <= ram_f(b_a2);
    end
    vga_frame_reader #(
        .BASE_ADDR(18'd258048), .IMG_W(40), .IMG_H(30), .READ_LATENCY(3),
        .H_VISIBLE(40), .H_SYNC_START(44), .H_SYNC_END(47), .H_TOTAL(52),
        .V_VISIBLE(30), .V_SYNC_START(32), .V_SYNC_END(33), .V_TOTAL(36)
    ) u_b (
        .CLK(CLK), .RST(RST), .en(en), .mem_data_b(b_mem), .address_b(b_addr),
        .vga_hs(b_hs), .vga_vs(b_vs), .vga_blank_n(b_bl),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .frame_start(b_fs)
    );

    // ---------------- DUT D: default 640x480 parameters ----------------
    logic [23:0] d_mem;
    logic [17:0] d_addr, d_a1;
    logic        d_hs, d_vs, d_bl, d_fs;
    logic [7:0]  d_r, d_g, d_b;
    always @(posedge CLK) begin
        d_a1  <= d_addr;
        d_mem <= ram_f(d_a1);
    end
    vga_frame_reader u_d (
        .CLK(CLK), .RST(RST), .en(en), .mem_data_b(d_mem), .address_b(d_addr),
        .vga_hs(d_hs), .vga_vs(d_vs), .vga_blank_n(d_bl),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .frame_start(d_fs)
    );

    // ---------------- reference model ----------------
    // Frame f shows the image iff en was high in the last cycle of frame f-1; frame 0 never does
    function automatic bit frame_act(int f, int ft);
        if (f == 0) return 1'b0;
        return en_log[f*ft-1];
    endfunction

    // Pointer during cycle n: base plus the number of image pixels already passed this frame
    function automatic logic [17:0] ptr_at(cfg_t c, int n);
        int ft  = c.ht * c.vt;
        int pos = n % ft;
        int h   = pos % c.ht;
        int v   = pos / c.ht;
        int cnt;
        if (!frame_act(n / ft, ft)) cnt = 0;
        else if (v < c.ih)          cnt = v * c.iw + ((h < c.iw) ? h : c.iw);
        else                        cnt = c.iw * c.ih;
        return 18'(c.base + cnt);
    endfunction

    function automatic exp_t model(cfg_t c, int n);
        exp_t e;
        int   ft, p, h, v;
        bit   act;
        e.addr    = ptr_at(c, n);
        e.hs      = 1'b1;
        e.vs      = 1'b1;
        e.blank_n = 1'b0;
        e.fs      = 1'b0;
        e.rgb     = 24'h0;
        if (n >= c.lat) begin
            ft  = c.ht * c.vt;
            p   = n - c.lat;
            h   = (p % ft) % c.ht;
            v   = (p % ft) / c.ht;
            act = frame_act(p / ft, ft);
            e.hs      = !(h >= c.hss && h <= c.hse);
            e.vs      = !(v >= c.vss && v <= c.vse);
            e.blank_n = (h < c.hv) && (v < c.vv);
            e.fs      = act && (h == 0) && (v == 0);
            if (act && h < c.iw && v < c.ih) e.rgb = ram_f(18'(c.base + v * c.iw + h));
        end
        return e;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic check_dut(input string nm, input exp_t e, input logic hs, input logic vs,
                             input logic bl, input logic fs, input logic [23:0] rgb,
                             input logic [17:0] addr);
        check({nm, ".hs"},    32'(hs),   32'(e.hs));
        check({nm, ".vs"},    32'(vs),   32'(e.vs));
        check({nm, ".blank"}, 32'(bl),   32'(e.blank_n));
        check({nm, ".fs"},    32'(fs),   32'(e.fs));
        check({nm, ".rgb"},   32'(rgb),  32'(e.rgb));
        check({nm, ".addr"},  32'(addr), 32'(e.addr));
    endtask

    task automatic check_all(input int n);
        check_dut("A", model(cfg_a, n), a_hs, a_vs, a_bl, a_fs, {a_r, a_g, a_b}, a_addr);
        check_dut("B", model(cfg_b, n), b_hs, b_vs, b_bl, b_fs, {b_r, b_g, b_b}, b_addr);
        check_dut("D", model(cfg_d, n), d_hs, d_vs, d_bl, d_fs, {d_r, d_g, d_b}, d_addr);
    endtask

    // Run ncyc cycles from the current negedge; en toggles randomly when rate > 0
    task automatic run(input int ncyc, input int rate);
        for (int i = 0; i < ncyc; i++) begin
            if (rate > 0 && $urandom_range(rate - 1, 0) == 0) en = ~en;
            en_log[k] = en;
            check_all(k);
            @(negedge CLK);
            k++;
        end
    endtask

    initial begin
        cfg_a = '{hv: 40, hss: 44, hse: 47, ht: 52, vv: 30, vss: 32, vse: 33, vt: 36,
                  iw: 16, ih: 12, base: 100, lat: 2};
        cfg_b = '{hv: 40, hss: 44, hse: 47, ht: 52, vv: 30, vss: 32, vse: 33, vt: 36,
                  iw: 40, ih: 30, base: 258048, lat: 3};
        cfg_d = '{hv: 640, hss: 656, hse: 751, ht: 800, vv: 480, vss: 490, vse: 491, vt: 525,
                  iw: 256, ih: 256, base: 0, lat: 2};
        salt = 24'($urandom);
        RST  = 1'b1;
        en   = 1'b0;
        k    = 0;

        // Held reset: every output at its idle value
        repeat (3) @(negedge CLK);
        check_all(0);

        // First frame always black; en rises mid-frame 0 so frames 1 and 2 carry the image
        RST = 1'b0;
        run(900, 0);
        en = 1'b1;
        run(2 * 1872 - 900, 0);
        // Random enable changes across several frames, then a random mid-frame stop point
        run(4 * 1872 + int'($urandom_range(1871, 0)), 1500);

        // Asynchronous reset between clock edges
        #2 RST = 1'b1;
        #1 check_all(0);
        @(negedge CLK);
        @(negedge CLK);
        check_all(0);

        // Restart from (0,0); enable already high, so the image returns from frame 1
        en  = 1'b1;
        RST = 1'b0;
        k   = 0;
        run(2 * 1872, 0);
        run(3 * 1872, 1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
